// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: accepts one request, checks it, drives the data RAM ports and
// returns a single response per request over a valid/ready handshake.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_LIMIT     = 4096,
  parameter bit          MISALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        resp_is_store,
  output logic        mem_we,
  output logic [2:0]  mem_wr_ctrl,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [2:0]  mem_rd_ctrl,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [2:0] {StIdle, StStore, StLoadIssue, StLoadWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        illegal, misalign, out_of_range, acc_err, accept;

  logic        mem_we_q;
  logic [2:0]  wr_ctrl_q, rd_ctrl_q;
  logic [31:0] wr_addr_q, wr_data_q, rd_addr_q, resp_data_q;
  logic [4:0]  resp_rd_q;
  logic        resp_err_q, resp_is_store_q;

  always_comb begin
    addr = req_base + req_offset;
    size = 3'd1;
    illegal = 1'b1;
    case (req_funct3)
      3'b000: begin size = 3'd1; illegal = 1'b0; end
      3'b001: begin size = 3'd2; illegal = 1'b0; end
      3'b010: begin size = 3'd4; illegal = 1'b0; end
      3'b100: begin size = 3'd1; illegal = req_is_store; end
      3'b101: begin size = 3'd2; illegal = req_is_store; end
      default: begin size = 3'd1; illegal = 1'b1; end
    endcase
    misalign = MISALIGN_CHECK &&
               (((req_funct3[1:0] == 2'b01) && addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
    // 33-bit sum so an access that wraps past 2^32 still counts as out of range.
    end_addr     = {1'b0, addr} + {30'd0, size};
    out_of_range = end_addr > 33'(ADDR_LIMIT);
    acc_err      = illegal || misalign || out_of_range;
    accept       = req_valid && (state_q == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (acc_err)           state_d = StResp;
          else if (req_is_store) state_d = StStore;
          else                   state_d = StLoadIssue;
        end
      end
      StStore:     state_d = StResp;
      StLoadIssue: state_d = StLoadWait;
      StLoadWait:  state_d = StResp;
      StResp:      if (resp_ready) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == StIdle);
    resp_valid    = (state_q == StResp);
    resp_data     = resp_data_q;
    resp_rd       = resp_rd_q;
    resp_err      = resp_err_q;
    resp_is_store = resp_is_store_q;
    mem_we        = mem_we_q;
    mem_wr_ctrl   = wr_ctrl_q;
    mem_wr_addr   = wr_addr_q;
    mem_wr_data   = wr_data_q;
    mem_rd_ctrl   = rd_ctrl_q;
    mem_rd_addr   = rd_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q        <= 1'b0;
      wr_ctrl_q       <= 3'b010;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      rd_ctrl_q       <= 3'b010;
      rd_addr_q       <= '0;
      resp_data_q     <= '0;
      resp_rd_q       <= '0;
      resp_err_q      <= 1'b0;
      resp_is_store_q <= 1'b0;
    end else begin
      if (accept) begin
        resp_rd_q       <= req_rd;
        resp_is_store_q <= req_is_store;
        if (acc_err) begin
          resp_err_q  <= 1'b1;
          resp_data_q <= addr;
        end else begin
          resp_err_q  <= 1'b0;
          resp_data_q <= '0;
          if (req_is_store) begin
            mem_we_q  <= 1'b1;
            wr_ctrl_q <= req_funct3;
            wr_addr_q <= addr;
            wr_data_q <= req_wdata;
          end else begin
            rd_ctrl_q <= req_funct3;
            rd_addr_q <= addr;
          end
        end
      end
      if (state_q == StStore) begin
        mem_we_q <= 1'b0;
      end
      if (state_q == StLoadWait) begin
        resp_data_q <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte RAM model with registered, extending read port, a table of
// requests checked through a scoreboard, and hand-written stall and reset sequences.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_base = '0, req_offset = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err, resp_is_store;
  logic        mem_we;
  logic [2:0]  mem_wr_ctrl, mem_rd_ctrl;
  logic [31:0] mem_wr_addr, mem_wr_data, mem_rd_addr;
  logic [31:0] mem_rd_data = '0;

  int errors = 0;
  int checks = 0;

  lsu_mem_ctrl #(.ADDR_LIMIT(4096), .MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err), .resp_is_store(resp_is_store),
    .mem_we(mem_we), .mem_wr_ctrl(mem_wr_ctrl), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_ctrl(mem_rd_ctrl), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // RAM model: little-endian bytes, registered read with extension chosen by rd_ctrl.
  logic [7:0] ram [0:4095];

  function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [2:0] c);
    logic [31:0] w;
    w = {ram[(a + 3) & 32'hFFF], ram[(a + 2) & 32'hFFF], ram[(a + 1) & 32'hFFF], ram[a & 32'hFFF]};
    case (c)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_wr_addr & 32'hFFF] <= mem_wr_data[7:0];
      if (mem_wr_ctrl != 3'b000) ram[(mem_wr_addr + 1) & 32'hFFF] <= mem_wr_data[15:8];
      if (mem_wr_ctrl == 3'b010) begin
        ram[(mem_wr_addr + 2) & 32'hFFF] <= mem_wr_data[23:16];
        ram[(mem_wr_addr + 3) & 32'hFFF] <= mem_wr_data[31:24];
      end
    end
    mem_rd_data <= ram_read(mem_rd_addr, mem_rd_ctrl);
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] edata;
    logic        eerr;
    int          elat;
  } vec_t;

  vec_t vecs [21];
  vec_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    req_is_store = v.st;
    req_funct3   = v.f3;
    req_base     = v.base;
    req_offset   = v.off;
    req_wdata    = v.wdata;
    req_rd       = v.rd;
    req_valid    = 1'b1;
    sb.push_back(v);
  endtask

  // Waits for acceptance, then watches the RAM ports every cycle until the response shows.
  task automatic accept_and_wait(output int lat, output int we_cycles);
    int          guard;
    vec_t        v;
    logic [31:0] a, rd_addr_before;
    guard = 0;
    v = sb[0];
    a = v.base + v.off;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    rd_addr_before = mem_rd_addr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    we_cycles = 0;
    while (!resp_valid && lat < 8) begin
      if (mem_we) begin
        we_cycles++;
        check("wr_addr", mem_wr_addr, a);
        check("wr_ctrl", {29'd0, mem_wr_ctrl}, {29'd0, v.f3});
        check("wr_data", mem_wr_data, v.wdata);
      end
      if (!v.st && !v.eerr) begin
        check("rd_addr_hold", mem_rd_addr, a);
        check("rd_ctrl_hold", {29'd0, mem_rd_ctrl}, {29'd0, v.f3});
      end
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    if (v.eerr) check("err_no_read", mem_rd_addr, rd_addr_before);
  endtask

  task automatic compare_resp(input int lat, input int we_cycles);
    vec_t v;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    v = sb.pop_front();
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_data", resp_data, v.edata);
    check("resp_err", {31'd0, resp_err}, {31'd0, v.eerr});
    check("resp_rd", {27'd0, resp_rd}, {27'd0, v.rd});
    check("resp_is_store", {31'd0, resp_is_store}, {31'd0, v.st});
    check("latency", 32'(lat), 32'(v.elat));
    check("we_cycles", 32'(we_cycles), (v.st && !v.eerr) ? 32'd1 : 32'd0);
  endtask

  task automatic handshake();
    @(posedge clk);
    #1;
    check("hs_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("hs_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat, wec;
    issue(v);
    accept_and_wait(lat, wec);
    compare_resp(lat, wec);
    handshake();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_wr_ctrl"}, {29'd0, mem_wr_ctrl}, 32'd2);
    check({tag, "_rd_ctrl"}, {29'd0, mem_rd_ctrl}, 32'd2);
    check({tag, "_wr_addr"}, mem_wr_addr, 32'd0);
    check({tag, "_wr_data"}, mem_wr_data, 32'd0);
    check({tag, "_rd_addr"}, mem_rd_addr, 32'd0);
    check({tag, "_resp_data"}, resp_data, 32'd0);
    check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    check({tag, "_resp_rd"}, {27'd0, resp_rd}, 32'd0);
    check({tag, "_resp_is_store"}, {31'd0, resp_is_store}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int          lat, wec;
    logic [31:0] snap_data;
    vec_t        v;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;

    //            st    f3      base          off           wdata         rd  edata         err lat
    vecs[0]  = '{1'b1, 3'b010, 32'h100,      32'h4,        32'hDEADBEEF, 1,  32'h0,        0, 1};
    vecs[1]  = '{1'b0, 3'b010, 32'h100,      32'h4,        32'h0,        2,  32'hDEADBEEF, 0, 2};
    vecs[2]  = '{1'b0, 3'b000, 32'h104,      32'h0,        32'h0,        3,  32'hFFFFFFEF, 0, 2};
    vecs[3]  = '{1'b0, 3'b100, 32'h104,      32'h0,        32'h0,        4,  32'h000000EF, 0, 2};
    vecs[4]  = '{1'b0, 3'b101, 32'h106,      32'h0,        32'h0,        5,  32'h0000DEAD, 0, 2};
    vecs[5]  = '{1'b0, 3'b001, 32'h106,      32'h0,        32'h0,        6,  32'hFFFFDEAD, 0, 2};
    vecs[6]  = '{1'b0, 3'b010, 32'h100,      32'h2,        32'h0,        7,  32'h102,      1, 0};
    vecs[7]  = '{1'b1, 3'b011, 32'h200,      32'h0,        32'h55,       8,  32'h200,      1, 0};
    vecs[8]  = '{1'b1, 3'b010, 32'h1000,     32'h0,        32'hCAFEF00D, 9,  32'h1000,     1, 0};
    vecs[9]  = '{1'b1, 3'b000, 32'hFF0,      32'hF,        32'h1234565A, 10, 32'h0,        0, 1};
    vecs[10] = '{1'b0, 3'b100, 32'hFFF,      32'h0,        32'h0,        11, 32'h0000005A, 0, 2};
    vecs[11] = '{1'b1, 3'b001, 32'hFFE,      32'h0,        32'hABCD8001, 12, 32'h0,        0, 1};
    vecs[12] = '{1'b0, 3'b001, 32'hFFE,      32'h0,        32'h0,        13, 32'hFFFF8001, 0, 2};
    vecs[13] = '{1'b0, 3'b010, 32'hFFE,      32'h0,        32'h0,        14, 32'hFFE,      1, 0};
    vecs[14] = '{1'b1, 3'b010, 32'hFFFFFFFC, 32'h8,        32'h0BADF00D, 15, 32'h0,        0, 1};
    vecs[15] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h8,        32'h0,        16, 32'h0BADF00D, 0, 2};
    vecs[16] = '{1'b0, 3'b010, 32'hFFC,      32'h0,        32'h0,        17, 32'h80010000, 0, 2};
    vecs[17] = '{1'b0, 3'b110, 32'h300,      32'h0,        32'h0,        18, 32'h300,      1, 0};
    vecs[18] = '{1'b1, 3'b100, 32'h40,       32'hFFFFFFFC, 32'h77,       19, 32'h3C,       1, 0};
    vecs[19] = '{1'b0, 3'b001, 32'h101,      32'h0,        32'h0,        20, 32'h101,      1, 0};
    vecs[20] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        21, 32'hFFFFFFFC, 1, 0};

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    for (int i = 0; i < 21; i++) run_vec(vecs[i]);

    // Response stall with a request already waiting behind it.
    resp_ready = 1'b0;
    v = '{1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 22, 32'hDEADBEEF, 0, 2};
    issue(v);
    accept_and_wait(lat, wec);
    compare_resp(lat, wec);
    snap_data = resp_data;
    v = '{1'b0, 3'b100, 32'h104, 32'h0, 32'h0, 23, 32'h000000EF, 0, 2};
    issue(v);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_data", resp_data, snap_data);
      check("stall_rd", {27'd0, resp_rd}, 32'd22);
      check("stall_err", {31'd0, resp_err}, 32'd0);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    handshake();
    accept_and_wait(lat, wec);
    compare_resp(lat, wec);
    handshake();

    // Reset while a load sits in LOAD_WAIT.
    @(negedge clk);
    req_is_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h104; req_offset = 32'h0;
    req_rd = 5'd24; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_load_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    run_vec(vecs[1]);

    // Reset while a store is driving the write port: the write must not land.
    @(negedge clk);
    req_is_store = 1'b1; req_funct3 = 3'b010; req_base = 32'h104; req_offset = 32'h0;
    req_wdata = 32'h11111111; req_rd = 5'd25; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_store_we_before", {31'd0, mem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_store");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_store_no_resp", {31'd0, resp_valid}, 32'd0);
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
